// File: rtl/turn_sequencer_if.sv
// Handshake bundle between the turn sequencer, the two move sources and the board-update logic.
// master = sequencer side, slave = front ends / link / board logic.
interface turn_sequencer_if;
   logic                  start;
   logic                  local_is_black;
   logic                  local_move_ready;
   logic [7:0]            local_move;
   logic                  remote_move_ready;
   logic [7:0]            remote_move;
   logic [8:0][8:0][1:0]  board;
   logic                  apply_done;
   logic                  local_turn;
   logic                  remote_turn;
   logic                  apply_valid;
   logic [7:0]            apply_move;
   logic [1:0]            apply_color;
   logic                  reject;
   logic                  game_over;
   logic [1:0]            current_color;
   logic [7:0]            move_count;
   logic [1:0]            pass_count;

   modport master (
      input  start, local_is_black, local_move_ready, local_move,
             remote_move_ready, remote_move, board, apply_done,
      output local_turn, remote_turn, apply_valid, apply_move, apply_color,
             reject, game_over, current_color, move_count, pass_count
   );

   modport slave (
      output start, local_is_black, local_move_ready, local_move,
             remote_move_ready, remote_move, board, apply_done,
      input  local_turn, remote_turn, apply_valid, apply_move, apply_color,
             reject, game_over, current_color, move_count, pass_count
   );
endinterface

// File: rtl/turn_sequencer.sv
// Go game-flow controller: turn grants, move legality, apply handshake,
// per-turn timeout (forced pass) and end of game on two consecutive passes.
module turn_sequencer #(
   parameter int              TO_W           = 26,
   parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 26'd50_000_000
) (
   input  logic             clk_in,
   input  logic             reset,
   turn_sequencer_if.master bus
);
   typedef enum logic [6:0] {
      IDLE      = 7'b0000001,
      GRANT     = 7'b0000010,
      CHECK     = 7'b0000100,
      APPLY     = 7'b0001000,
      WAIT_DONE = 7'b0010000,
      SWITCH    = 7'b0100000,
      OVER      = 7'b1000000
   } state_t;

   localparam logic [1:0] BLACK = 2'b01;
   localparam logic [1:0] WHITE = 2'b10;
   localparam logic [7:0] PASS  = 8'hFF;

   state_t          state;
   logic            lib;
   logic [TO_W-1:0] timer;
   logic [7:0]      mv;
   logic            illegal_q;

   logic       owner_local;
   logic       own_ready;
   logic [7:0] own_move;
   logic       occupied;
   logic       illegal;

   assign owner_local = (bus.current_color == BLACK) == lib;
   assign own_ready   = owner_local ? bus.local_move_ready : bus.remote_move_ready;
   assign own_move    = owner_local ? bus.local_move : bus.remote_move;

   // Legality is resolved in GRANT so reject can be a registered pulse during CHECK.
   always_comb begin
      occupied = 1'b0;
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++)
            if (own_move[7:4] == 4'(r) && own_move[3:0] == 4'(c) && bus.board[r][c] != 2'b00)
               occupied = 1'b1;
      illegal = (own_move != PASS) &&
                (own_move[7:4] > 4'd8 || own_move[3:0] > 4'd8 || occupied);
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         lib               <= 1'b0;
         timer             <= '0;
         mv                <= 8'h00;
         illegal_q         <= 1'b0;
         bus.local_turn    <= 1'b0;
         bus.remote_turn   <= 1'b0;
         bus.apply_valid   <= 1'b0;
         bus.apply_move    <= 8'h00;
         bus.apply_color   <= 2'b00;
         bus.reject        <= 1'b0;
         bus.game_over     <= 1'b0;
         bus.current_color <= 2'b00;
         bus.move_count    <= 8'd0;
         bus.pass_count    <= 2'd0;
      end else begin
         bus.apply_valid <= 1'b0;
         bus.reject      <= 1'b0;
         case (state)
            IDLE, OVER: if (bus.start) begin
               state             <= GRANT;
               lib               <= bus.local_is_black;
               timer             <= '0;
               bus.current_color <= BLACK;
               bus.move_count    <= 8'd0;
               bus.pass_count    <= 2'd0;
               bus.game_over     <= 1'b0;
               bus.local_turn    <= bus.local_is_black;
               bus.remote_turn   <= ~bus.local_is_black;
            end
            GRANT: begin
               if (own_ready || timer == TIMEOUT_CYCLES - 1'b1) begin
                  state           <= CHECK;
                  mv              <= own_ready ? own_move : PASS;
                  illegal_q       <= own_ready && illegal;
                  bus.reject      <= own_ready && illegal;
                  bus.local_turn  <= 1'b0;
                  bus.remote_turn <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            CHECK: begin
               if (mv == PASS) begin
                  bus.pass_count <= bus.pass_count + 2'd1;
                  if (bus.pass_count == 2'd1) begin
                     state         <= OVER;
                     bus.game_over <= 1'b1;
                  end else begin
                     state <= SWITCH;
                  end
               end else if (illegal_q) begin
                  state           <= GRANT;
                  timer           <= '0;
                  bus.local_turn  <= owner_local;
                  bus.remote_turn <= ~owner_local;
               end else begin
                  state           <= APPLY;
                  bus.pass_count  <= 2'd0;
                  bus.apply_valid <= 1'b1;
                  bus.apply_move  <= mv;
                  bus.apply_color <= bus.current_color;
               end
            end
            APPLY: state <= WAIT_DONE;
            WAIT_DONE: if (bus.apply_done) begin
               state <= SWITCH;
               if (bus.move_count != 8'hFF) bus.move_count <= bus.move_count + 8'd1;
            end
            SWITCH: begin
               state             <= GRANT;
               timer             <= '0;
               bus.current_color <= (bus.current_color == BLACK) ? WHITE : BLACK;
               // Next owner is local iff the incoming colour (black when leaving white) matches lib.
               bus.local_turn    <= (bus.current_color == WHITE) == lib;
               bus.remote_turn   <= (bus.current_color == WHITE) != lib;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Game-flow controller for the 9x9 Go board. It decides whose turn it is between the local player (cursor/button front end) and the remote player (link receiver), and gates each side's move handshake with a turn grant. It rejects illegal coordinates and occupied points, forwards accepted moves to the board-update logic, and waits for that logic to acknowledge. It also enforces a per-turn timeout and detects end of game on two consecutive passes.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 26'd50_000_000: cycles allowed per turn before a forced pass.
- TO_W, default 26: width of the turn timer.

Ports:
- clk_in  in  1  system clock
- reset  in  1  asynchronous, active-high; all state and outputs cleared immediately
- start  in  1  one-cycle pulse; begins a new game (honoured in IDLE and OVER only)
- local_is_black  in  1  sampled on the accepted start; 1 = local player is black
- local_move_ready  in  1  one-cycle pulse from the local front end
- local_move  in  8  {row[7:4], col[3:0]}; 8'hFF = pass
- remote_move_ready  in  1  one-cycle pulse from the link receiver
- remote_move  in  8  same encoding as local_move
- board  in  2x9x9  occupancy [row][col]; 2'b00 = empty
- apply_done  in  1  board-update logic finished (captures resolved)
- local_turn  out  1  grant to the local front end
- remote_turn  out  1  grant to the remote side
- apply_valid  out  1  one-cycle pulse; apply_move/apply_color valid
- apply_move  out  8  accepted move
- apply_color  out  2  2'b01 black, 2'b10 white
- reject  out  1  one-cycle pulse on an illegal move
- game_over  out  1  high in OVER
- current_color  out  2  colour to move (2'b00 in IDLE)
- move_count  out  8  stones placed, saturates at 255
- pass_count  out  2  consecutive passes

## Operation
States: IDLE, GRANT, CHECK, APPLY, WAIT_DONE, SWITCH, OVER (one-hot).
- IDLE: grants low. start → GRANT. On entry to GRANT: colour = black, local_is_black latched, counters and timer cleared.
- Owner is local iff (colour==black) == latched local_is_black.
- GRANT:
  - The owner's grant is high and the timer increments.
  - The owner's ready latches its move and moves to CHECK. The non-owner's ready is ignored.
  - When the timer reaches TIMEOUT_CYCLES-1 with no ready, the latched move = 8'hFF → CHECK.
  - Ready and timeout in the same cycle: ready wins.
- CHECK (1 cycle):
  - move == 8'hFF: pass_count+1. If that makes 2 → OVER, otherwise → SWITCH.
  - Otherwise, if row>8, col>8, or board[row][col]!=0: reject pulses and the state returns to GRANT with the timer cleared. Same owner and colour, pass_count unchanged.
  - Otherwise: pass_count ← 0 → APPLY.
- APPLY: apply_valid=1 for exactly one cycle, with apply_move/apply_color held → WAIT_DONE.
- WAIT_DONE: apply_move/apply_color stay stable. apply_done → SWITCH. move_count+1 (saturating) on leaving.
- SWITCH (1 cycle): colour toggles, timer cleared → GRANT.
- OVER: game_over=1, grants low, counters frozen. start → new game as from IDLE.
- start outside IDLE/OVER is ignored. apply_done outside WAIT_DONE is ignored.

## Timing
- Reset values: local_turn=0, remote_turn=0, apply_valid=0, apply_move=8'h00, apply_color=2'b00, reject=0, game_over=0, current_color=2'b00, move_count=0, pass_count=0; state IDLE.
- Grants, apply_valid, reject and game_over are decoded from registered state only; no combinational path from any input.
- start in cycle N → grant high in N+1.
- Ready sampled in cycle N (GRANT) → grant low from N+1 (CHECK), apply_valid in N+2, reject in N+1 (registered).
- apply_done in cycle M → SWITCH in M+1 → next owner's grant in M+2.
- Illegal move: grant drops for exactly one cycle (CHECK), then re-asserts.
- Timer width TO_W. The compare is exact; no wrap occurs because the timer clears on every GRANT entry.
- Asynchronous reset mid-game (including during WAIT_DONE) abandons the pending apply; no apply_valid follows.

## Test plan
- Reset, then start with local_is_black=1 → local_turn=1 at N+1. local_move_ready with 8'h44 → apply_valid with apply_move=8'h44, apply_color=01 two cycles later. apply_done → remote_turn=1, current_color=10, move_count=1.
- During the local turn, pulse remote_move_ready with 8'h00 → ignored: no CHECK, local_turn stays 1.
- With board[4][4]=01, the owner submits 8'h44, then 8'h94 (row 9) → reject pulses once each, grant re-asserts, no apply_valid, colour unchanged.
- Black passes (8'hFF), then white passes → pass_count 1 then 2, game_over=1, both grants 0. Then start → new game: current_color=01, move_count=0.
- Pass, then a legal stone, then a pass → pass_count returns to 0 after the stone and no game_over. Set TIMEOUT_CYCLES=16 with no ready → forced pass after 16 GRANT cycles; ready in the expiry cycle → the real move is taken.
- Assert reset during WAIT_DONE → all outputs return to reset values immediately and no apply_valid follows. Afterwards start works normally.
